// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch front end: registered fetch PC, single-outstanding
//   request/acknowledge memory handshake, DEPTH-entry circular prefetch queue
//   and branch/jump redirect with discard of an in-flight fetch.
//
// Ports
//   clk, rst               clock (rising edge), async active-high reset
//   mem_req, mem_addr      fetch request and its address (held until ack)
//   mem_ack, mem_rdata     memory response strobe and instruction word
//   instr_valid, instr,    queue head: valid flag, instruction and its PC
//   instr_pc
//   instr_ready            consumer accepts the head this cycle
//   redirect, redirect_pc  flush the queue and restart fetch at redirect_pc
//   count                  current queue occupancy (0..DEPTH)
// ---------------------------------------------------------------------------
module fetch_unit #(
   parameter int                DATA_W   = 16,
   parameter int                ADDR_W   = 16,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int                PC_STEP  = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   output logic                     mem_req,
   output logic [ADDR_W-1:0]        mem_addr,
   input  logic                     mem_ack,
   input  logic [DATA_W-1:0]        mem_rdata,
   output logic                     instr_valid,
   output logic [DATA_W-1:0]        instr,
   output logic [ADDR_W-1:0]        instr_pc,
   input  logic                     instr_ready,
   input  logic                     redirect,
   input  logic [ADDR_W-1:0]        redirect_pc,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int                PTR_W = $clog2(DEPTH);
   localparam int                CNT_W = PTR_W + 1;
   localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(PC_STEP);
   localparam logic [CNT_W-1:0]  FULL  = CNT_W'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,  // no request outstanding
      S_REQ,   // request for fetch_pc outstanding
      S_DROP   // outstanding request belongs to a flushed stream
   } state_t;

   state_t              state, state_next;
   logic [ADDR_W-1:0]   fetch_pc, fetch_pc_next;
   logic [ADDR_W-1:0]   req_addr, req_addr_next;
   logic [PTR_W-1:0]    rd_ptr, wr_ptr;
   logic [CNT_W-1:0]    occ;
   logic [DATA_W-1:0]   q_data [DEPTH];
   logic [ADDR_W-1:0]   q_pc   [DEPTH];

   logic                pop, push;
   logic [CNT_W-1:0]    occ_after_pop;
   logic                space_now, space_after_push;

   assign pop  = instr_valid & instr_ready & ~redirect;
   assign push = (state == S_REQ) & mem_ack & ~redirect;

   // Occupancy seen by the issue logic already accounts for this cycle's pop,
   // so a full queue that is being drained can issue without a bubble.
   assign occ_after_pop    = occ - CNT_W'(pop);
   assign space_now        = occ_after_pop < FULL;
   assign space_after_push = (occ_after_pop + CNT_W'(1)) < FULL;

   // Next-state / next-address logic.
   always_comb begin
      // NOTE: every variable gets a default before any branch, so no path
      // leaves it unassigned and no latch is inferred.
      state_next    = state;
      fetch_pc_next = fetch_pc;
      req_addr_next = req_addr;
      if (redirect) begin
         fetch_pc_next = redirect_pc;
         unique case (state)
            S_IDLE: begin
               state_next    = S_REQ;
               req_addr_next = redirect_pc;
            end
            S_REQ: begin
               if (mem_ack) begin
                  // Response arrives with the redirect: drop it, reissue.
                  state_next    = S_REQ;
                  req_addr_next = redirect_pc;
               end else begin
                  // Handshake cannot be withdrawn; keep the old address.
                  state_next = S_DROP;
               end
            end
            default: state_next = S_DROP;
         endcase
      end else begin
         unique case (state)
            S_IDLE: begin
               if (space_now) begin
                  state_next    = S_REQ;
                  req_addr_next = fetch_pc;
               end
            end
            S_REQ: begin
               if (mem_ack) begin
                  fetch_pc_next = fetch_pc + STEP;
                  if (space_after_push) begin
                     req_addr_next = fetch_pc + STEP;
                  end else begin
                     state_next = S_IDLE;
                  end
               end
            end
            default: begin
               if (mem_ack) begin
                  state_next    = S_REQ;
                  req_addr_next = fetch_pc;
               end
            end
         endcase
      end
   end

   // Control state, PCs, queue pointers and occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         fetch_pc <= RESET_PC;
         req_addr <= RESET_PC;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         occ      <= '0;
      end else begin
         // NOTE: non-blocking assignments here so every register samples the
         // pre-edge values, independent of statement order.
         state    <= state_next;
         fetch_pc <= fetch_pc_next;
         req_addr <= req_addr_next;
         if (redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            occ <= occ + CNT_W'(push) - CNT_W'(pop);
         end
      end
   end

   // NOTE: queue storage has no reset; entries are only read while occupied,
   // and the outputs are masked to zero when the queue is empty.
   always_ff @(posedge clk) begin
      if (push) begin
         q_data[wr_ptr] <= mem_rdata;
         q_pc[wr_ptr]   <= fetch_pc;
      end
   end

   assign mem_req     = (state != S_IDLE);
   assign mem_addr    = req_addr;
   assign count       = occ;
   assign instr_valid = (occ != '0);
   assign instr       = instr_valid ? q_data[rd_ptr] : '0;
   assign instr_pc    = instr_valid ? q_pc[rd_ptr]   : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//   Self-checking bench for fetch_unit (default parameters). A behavioural
//   memory answers each request after mem_lat wait cycles with the word
//   addr+0x1000. The reference model is the architectural instruction
//   stream: after reset or a redirect to P, the consumer must see P, P+1, ...
//   with no gaps, no duplicates and no flushed words.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 16;
   localparam int DEPTH  = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ack = 1'b0;
   logic [DATA_W-1:0] mem_rdata = '0;
   logic              instr_valid;
   logic [DATA_W-1:0] instr;
   logic [ADDR_W-1:0] instr_pc;
   logic              instr_ready;
   logic              redirect;
   logic [ADDR_W-1:0] redirect_pc;
   logic [2:0]        count;

   int                n_tests = 0;
   int                n_fail  = 0;
   int                mem_lat = 0;
   int                wait_cnt = 0;
   logic [ADDR_W-1:0] hs_q[$];   // addresses of acknowledged requests

   fetch_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
      .instr_ready(instr_ready),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .count(count)
   );

   always #5 clk = ~clk;

   function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
      return a + 16'h1000;
   endfunction

   // Memory model: ack after mem_lat full cycles of mem_req.
   always @(negedge clk) begin
      if (mem_ack || !mem_req) wait_cnt = 0;
      if (mem_req && wait_cnt >= mem_lat) begin
         mem_ack   = 1'b1;
         mem_rdata = mem_word(mem_addr);
         hs_q.push_back(mem_addr);
      end else begin
         mem_ack = 1'b0;
         if (mem_req) wait_cnt++;
      end
   end

   // Sample/drive point: just after the falling edge.
   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
      step(); step();
      rst = 1'b0;
      hs_q.delete();
   endtask

   task automatic test_reset();
      bit found;
      rst = 1'b1; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
      mem_lat = 0;
      step();
      n_tests += 6;
      if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
      if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
      if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
      if (mem_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0000", mem_addr); end
      if (instr !== 16'h0000) begin n_fail++; $display("FAIL reset_instr: got %h want 0000", instr); end
      if (instr_pc !== 16'h0000) begin n_fail++; $display("FAIL reset_instr_pc: got %h want 0000", instr_pc); end
      // Run until a request is outstanding with two words queued.
      rst = 1'b0;
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         step();
         if (mem_req === 1'b1 && count === 3'd2) found = 1;
      end
      n_tests++;
      if (!found) begin n_fail++; $display("FAIL reset_mid_setup: got timeout want count=2 with mem_req"); end
      rst = 1'b1;
      step();
      n_tests += 4;
      if (mem_req !== 1'b0) begin n_fail++; $display("FAIL midreset_mem_req: got %b want 0", mem_req); end
      if (count !== 3'd0) begin n_fail++; $display("FAIL midreset_count: got %0d want 0", count); end
      if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_valid: got %b want 0", instr_valid); end
      if (mem_addr !== 16'h0000) begin n_fail++; $display("FAIL midreset_mem_addr: got %h want 0000", mem_addr); end
      rst = 1'b0;
      hs_q.delete();
      for (int i = 0; i < 10 && hs_q.size() == 0; i++) step();
      n_tests++;
      if (hs_q.size() == 0) begin n_fail++; $display("FAIL midreset_first_req: got none want 0000"); end
      else if (hs_q[0] !== 16'h0000) begin n_fail++; $display("FAIL midreset_first_req: got %h want 0000", hs_q[0]); end
   endtask

   task automatic test_stream();
      logic [ADDR_W-1:0] exp_pc;
      do_reset();
      mem_lat = 0; instr_ready = 1'b1;
      step();
      n_tests += 2;
      if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL stream_lat1_valid: got %b want 0", instr_valid); end
      if (mem_req !== 1'b1) begin n_fail++; $display("FAIL stream_lat1_req: got %b want 1", mem_req); end
      step();
      exp_pc = 16'h0000;
      for (int i = 0; i < 20; i++) begin
         n_tests++;
         if (instr_valid !== 1'b1 || instr_pc !== exp_pc || instr !== mem_word(exp_pc)) begin
            n_fail++;
            $display("FAIL stream_word%0d: got v=%b pc=%h d=%h want v=1 pc=%h d=%h",
                     i, instr_valid, instr_pc, instr, exp_pc, mem_word(exp_pc));
         end
         exp_pc++;
         step();
      end
      instr_ready = 1'b0;
   endtask

   task automatic test_full();
      do_reset();
      mem_lat = 0; instr_ready = 1'b0;
      repeat (10) step();
      n_tests += 4;
      if (hs_q.size() != DEPTH) begin n_fail++; $display("FAIL full_req_count: got %0d want %0d", hs_q.size(), DEPTH); end
      else begin
         for (int i = 0; i < DEPTH; i++)
            if (hs_q[i] !== ADDR_W'(i)) begin n_fail++; $display("FAIL full_req_addr%0d: got %h want %h", i, hs_q[i], ADDR_W'(i)); end
      end
      if (count !== 3'd4) begin n_fail++; $display("FAIL full_count: got %0d want 4", count); end
      if (mem_req !== 1'b0) begin n_fail++; $display("FAIL full_mem_req: got %b want 0", mem_req); end
      if (instr_pc !== 16'h0000 || instr !== 16'h1000) begin n_fail++; $display("FAIL full_head: got pc=%h d=%h want pc=0000 d=1000", instr_pc, instr); end
      instr_ready = 1'b1;
      step();
      instr_ready = 1'b0;
      n_tests += 2;
      if (count !== 3'd3) begin n_fail++; $display("FAIL full_pop_count: got %0d want 3", count); end
      if (mem_req !== 1'b1 || mem_addr !== 16'h0004) begin n_fail++; $display("FAIL full_refill_req: got req=%b addr=%h want req=1 addr=0004", mem_req, mem_addr); end
      step();
      n_tests += 2;
      if (count !== 3'd4 || mem_req !== 1'b0) begin n_fail++; $display("FAIL full_refill_done: got count=%0d req=%b want count=4 req=0", count, mem_req); end
      if (hs_q.size() != DEPTH + 1) begin n_fail++; $display("FAIL full_refill_total: got %0d want %0d", hs_q.size(), DEPTH + 1); end
   endtask

   task automatic test_redirect_drop();
      bit found, got_pop;
      int n;
      logic [ADDR_W-1:0] first_pc;
      logic [DATA_W-1:0] first_d;
      do_reset();
      mem_lat = 3; instr_ready = 1'b1;
      found = 0;
      for (int i = 0; i < 200 && !found; i++) begin
         step();
         if (mem_req === 1'b1 && mem_addr === 16'h0005) found = 1;
      end
      n_tests++;
      if (!found) begin n_fail++; $display("FAIL drop_setup: got timeout want request to 0005"); end
      step();
      n = hs_q.size();
      redirect = 1'b1; redirect_pc = 16'h0040;
      step();
      redirect = 1'b0;
      n_tests += 2;
      if (mem_req !== 1'b1 || mem_addr !== 16'h0005) begin n_fail++; $display("FAIL drop_hold: got req=%b addr=%h want req=1 addr=0005", mem_req, mem_addr); end
      if (count !== 3'd0 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL drop_flush: got count=%0d v=%b want 0 0", count, instr_valid); end
      got_pop = 0; first_pc = '0; first_d = '0;
      for (int i = 0; i < 40 && !got_pop; i++) begin
         if (hs_q.size() == n && mem_req === 1'b1) begin
            n_tests++;
            if (mem_addr !== 16'h0005) begin n_fail++; $display("FAIL drop_addr_stable: got %h want 0005", mem_addr); end
         end
         if (instr_valid === 1'b1) begin got_pop = 1; first_pc = instr_pc; first_d = instr; end
         step();
      end
      n_tests += 3;
      if (hs_q.size() < n + 2) begin n_fail++; $display("FAIL drop_handshakes: got %0d want >= %0d", hs_q.size(), n + 2); end
      else if (hs_q[n] !== 16'h0005 || hs_q[n+1] !== 16'h0040) begin
         n_fail++; $display("FAIL drop_req_order: got %h,%h want 0005,0040", hs_q[n], hs_q[n+1]);
      end
      if (!got_pop) begin n_fail++; $display("FAIL drop_first_pc: got timeout want 0040"); end
      else if (first_pc !== 16'h0040) begin n_fail++; $display("FAIL drop_first_pc: got %h want 0040", first_pc); end
      if (got_pop && first_d !== 16'h1040) begin n_fail++; $display("FAIL drop_first_data: got %h want 1040", first_d); end
      instr_ready = 1'b0;
   endtask

   // Redirect to target during steady streaming, then check the next words.
   task automatic redirect_stream(input string name, input logic [ADDR_W-1:0] target,
                                  input int n_words);
      logic [ADDR_W-1:0] exp_pc;
      int seen;
      do_reset();
      mem_lat = 0; instr_ready = 1'b1;
      repeat (6) step();
      n_tests++;
      if (mem_ack !== 1'b1 || instr_valid !== 1'b1) begin n_fail++; $display("FAIL %s_setup: got ack=%b v=%b want 1 1", name, mem_ack, instr_valid); end
      redirect = 1'b1; redirect_pc = target;
      step();
      redirect = 1'b0;
      n_tests += 2;
      if (count !== 3'd0 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL %s_flush: got count=%0d v=%b want 0 0", name, count, instr_valid); end
      if (mem_req !== 1'b1 || mem_addr !== target) begin n_fail++; $display("FAIL %s_next_req: got req=%b addr=%h want req=1 addr=%h", name, mem_req, mem_addr, target); end
      exp_pc = target; seen = 0;
      for (int i = 0; i < 20 && seen < n_words; i++) begin
         if (instr_valid === 1'b1) begin
            n_tests++;
            if (instr_pc !== exp_pc || instr !== mem_word(exp_pc)) begin
               n_fail++; $display("FAIL %s_word%0d: got pc=%h d=%h want pc=%h d=%h", name, seen, instr_pc, instr, exp_pc, mem_word(exp_pc));
            end
            exp_pc++; seen++;
         end
         step();
      end
      n_tests++;
      if (seen != n_words) begin n_fail++; $display("FAIL %s_words: got %0d want %0d", name, seen, n_words); end
      instr_ready = 1'b0;
   endtask

   task automatic test_random();
      logic [ADDR_W-1:0] exp_pc, hold_addr;
      bit hold;
      int pops;
      do_reset();
      exp_pc = 16'h0000; hold = 0; hold_addr = '0; pops = 0;
      for (int i = 0; i < 1500; i++) begin
         instr_ready = ($urandom_range(0, 3) != 0);
         redirect    = ($urandom_range(0, 24) == 0);
         redirect_pc = ADDR_W'($urandom);
         mem_lat     = $urandom_range(0, 2);
         n_tests += 2;
         if (instr_valid !== (count != 3'd0) || count > 3'd4) begin
            n_fail++; $display("FAIL rand_occ: got v=%b count=%0d want v=(count!=0) count<=4", instr_valid, count);
         end
         if (hold && (mem_req !== 1'b1 || mem_addr !== hold_addr)) begin
            n_fail++; $display("FAIL rand_req_hold: got req=%b addr=%h want req=1 addr=%h", mem_req, mem_addr, hold_addr);
         end
         if (instr_valid === 1'b1 && instr_ready && !redirect) begin
            n_tests++;
            if (instr_pc !== exp_pc || instr !== mem_word(exp_pc)) begin
               n_fail++; $display("FAIL rand_pop%0d: got pc=%h d=%h want pc=%h d=%h", pops, instr_pc, instr, exp_pc, mem_word(exp_pc));
            end
            exp_pc++; pops++;
         end
         if (redirect) exp_pc = redirect_pc;
         hold = (mem_req === 1'b1 && mem_ack !== 1'b1);
         hold_addr = mem_addr;
         step();
      end
      redirect = 1'b0; instr_ready = 1'b0;
      n_tests++;
      if (pops < 200) begin n_fail++; $display("FAIL rand_progress: got %0d pops want >= 200", pops); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_full();
      test_redirect_drop();
      redirect_stream("redir_ack", 16'h0080, 4);
      redirect_stream("wrap", 16'hFFFE, 3);
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
